jstk_poll_ctrl: RTL and testbench

//  Polls the joystick SPI front end (PmodJSTK) on a fixed period: drives its sndRec/DIN, tracks SS to detect frame done,

---
 rtl/jstk_poll_if.sv | 33 +++
 rtl/jstk_poll_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_jstk_poll_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/jstk_poll_if.sv
// -----------------------------------------------------------------------------
// jstk_poll_if
//   Signal bundle between the joystick poll controller and the PmodJSTK SPI
//   front end.
//
//   jstk_ss    SS from PmodJSTK, low while a frame is in progress
//   jstk_dout  40-bit frame returned by PmodJSTK
//   jstk_snd   sndRec request to PmodJSTK
//   jstk_din   command byte sent to PmodJSTK
//
//   master : the poll controller (drives snd/din, reads ss/dout)
//   slave  : the PmodJSTK front end
// -----------------------------------------------------------------------------
interface jstk_poll_if;
   logic        jstk_ss;
   logic [39:0] jstk_dout;
   logic        jstk_snd;
   logic [7:0]  jstk_din;

   modport master (
      input  jstk_ss,
      input  jstk_dout,
      output jstk_snd,
      output jstk_din
   );

   modport slave (
      output jstk_ss,
      output jstk_dout,
      input  jstk_snd,
      input  jstk_din
   );
endinterface

// File: rtl/jstk_poll_ctrl.sv
// -----------------------------------------------------------------------------
// jstk_poll_ctrl
//   Periodically polls the PmodJSTK front end, captures the 40-bit reply,
//   unpacks X/Y/buttons and turns them into a 4-way drive command with a
//   deadband around centre. A watchdog aborts transfers that never complete.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   en        in   polling enable (low: no new transfers start)
//   led       in   joystick LED states, sent in the command byte
//   jstk      if   master side of jstk_poll_if (ss/dout in, snd/din out)
//   x_pos     out  10-bit X position
//   y_pos     out  10-bit Y position
//   btn       out  button states
//   dir       out  {fwd, back, left, right}, one-hot or zero
//   data_vld  out  one-cycle pulse when x_pos/y_pos/btn/dir update
//   timeout   out  sticky abort flag, cleared by reset or next good frame
// -----------------------------------------------------------------------------
module jstk_poll_ctrl #(
   parameter int          CLK_HZ      = 100_000_000,
   parameter int          POLL_HZ     = 50,
   parameter int          TIMEOUT_CYC = 1_000_000,
   parameter logic [9:0]  DEADBAND    = 10'd100
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic [1:0]        led,
   jstk_poll_if.master       jstk,
   output logic [9:0]        x_pos,
   output logic [9:0]        y_pos,
   output logic [2:0]        btn,
   output logic [3:0]        dir,
   output logic              data_vld,
   output logic              timeout
);

   localparam int POLL_DIV    = CLK_HZ / POLL_HZ;
   localparam int POLL_W      = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_CAPT,
      S_DEC,
      S_ABORT
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [POLL_W-1:0]   r_poll_cnt;
   logic                w_tick;
   logic [WD_W-1:0]     r_wd;
   logic                w_wd_exp;

   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic                w_ss_s;

   logic                r_snd;
   logic [7:0]          r_din;
   logic [9:0]          r_x;
   logic [9:0]          r_y;
   logic [2:0]          r_btn;
   logic [3:0]          r_dir;
   logic                r_vld;
   logic                r_timeout;

   logic signed [10:0]  w_dx;
   logic signed [10:0]  w_dy;
   logic [10:0]         w_adx;
   logic [10:0]         w_ady;
   logic                w_in_db;
   logic [3:0]          w_dir;

   // ---------------------------------------------------------------------------
   // SS synchroniser: PmodJSTK runs from its own slow internal clock, so SS is
   // asynchronous here. Resets to idle-high so no false frame edge is seen.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_ss_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge CLK) begin
               if (RST) r_ss_sync[gi] <= 1'b1;
               else     r_ss_sync[gi] <= jstk.jstk_ss;
            end
         end else begin : g_rest
            always_ff @(posedge CLK) begin
               if (RST) r_ss_sync[gi] <= 1'b1;
               else     r_ss_sync[gi] <= r_ss_sync[gi-1];
            end
         end
      end
   endgenerate

   assign w_ss_s = r_ss_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Poll divider: free-runs while enabled, parked at zero otherwise, so the
   // first tick after enabling is a full period away.
   // ---------------------------------------------------------------------------
   assign w_tick = en && (r_poll_cnt == POLL_W'(POLL_DIV - 1));

   always_ff @(posedge CLK) begin
      if (RST || !en || w_tick) r_poll_cnt <= '0;
      else                      r_poll_cnt <= r_poll_cnt + 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Watchdog: restarted on entry to REQ, runs through REQ and XFER, and
   // saturates so a long stall cannot wrap back below the limit.
   // ---------------------------------------------------------------------------
   assign w_wd_exp = (r_wd >= WD_W'(TIMEOUT_CYC));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wd <= '0;
      end else if (r_state == S_IDLE && w_state_next == S_REQ) begin
         r_wd <= '0;
      end else if ((r_state == S_REQ || r_state == S_XFER) && !w_wd_exp) begin
         r_wd <= r_wd + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         // A tick while SS is still low (previous frame not released) is lost.
         S_IDLE:  if (w_tick && w_ss_s) w_state_next = S_REQ;
         S_REQ: begin
            if (!w_ss_s)       w_state_next = S_XFER;
            else if (w_wd_exp) w_state_next = S_ABORT;
         end
         S_XFER: begin
            if (w_ss_s)        w_state_next = S_CAPT;
            else if (w_wd_exp) w_state_next = S_ABORT;
         end
         S_CAPT:  w_state_next = S_DEC;
         S_DEC:   w_state_next = S_IDLE;
         S_ABORT: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Request / command byte. sndRec is registered from the next state so it is
   // high exactly while the FSM sits in REQ and drops the cycle after reset.
   // The command byte is sampled only when a new request is launched.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_snd <= 1'b0;
         r_din <= 8'h80;
      end else begin
         r_snd <= (w_state_next == S_REQ);
         if (r_state == S_IDLE && w_state_next == S_REQ)
            r_din <= {6'b100000, led};
      end
   end

   // ---------------------------------------------------------------------------
   // Direction decode from the captured position (offsets from centre 512).
   // ---------------------------------------------------------------------------
   assign w_dx    = $signed({1'b0, r_x}) - 11'sd512;
   assign w_dy    = $signed({1'b0, r_y}) - 11'sd512;
   // Magnitude never exceeds 512, so the 11-bit negation cannot overflow.
   assign w_adx   = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
   assign w_ady   = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
   assign w_in_db = (w_adx <= {1'b0, DEADBAND}) && (w_ady <= {1'b0, DEADBAND});

   always_comb begin
      w_dir = 4'b0000;
      if (!r_btn[0] && !w_in_db) begin
         // Vertical axis wins ties so a diagonal push drives forward/back.
         if (w_ady >= w_adx) begin
            if (w_dy[10]) w_dir = 4'b0100;
            else          w_dir = 4'b1000;
         end else begin
            if (w_dx[10]) w_dir = 4'b0010;
            else          w_dir = 4'b0001;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Capture, decode and status outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_x       <= 10'd512;
         r_y       <= 10'd512;
         r_btn     <= 3'b000;
         r_dir     <= 4'b0000;
         r_vld     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         case (r_state)
            S_CAPT: begin
               r_x   <= {jstk.jstk_dout[25:24], jstk.jstk_dout[39:32]};
               r_y   <= {jstk.jstk_dout[9:8],   jstk.jstk_dout[23:16]};
               r_btn <= jstk.jstk_dout[2:0];
            end
            S_DEC: begin
               r_dir     <= w_dir;
               r_vld     <= 1'b1;
               r_timeout <= 1'b0;
            end
            S_ABORT: begin
               // Lost link: stop the car, keep last position for diagnostics.
               r_dir     <= 4'b0000;
               r_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign jstk.jstk_snd = r_snd;
   assign jstk.jstk_din = r_din;
   assign x_pos         = r_x;
   assign y_pos         = r_y;
   assign btn           = r_btn;
   assign dir           = r_dir;
   assign data_vld      = r_vld;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jstk_poll_ctrl
//   Directed bench for jstk_poll_ctrl with a behavioural PmodJSTK SS model.
//   Small clock/poll/timeout parameters keep each frame a few hundred cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jstk_poll_ctrl;

   localparam int CLK_HZ      = 400;
   localparam int POLL_HZ     = 1;
   localparam int TIMEOUT_CYC = 300;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       en  = 1'b0;
   logic [1:0] led = 2'b00;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic [2:0] btn;
   logic [3:0] dir;
   logic       data_vld;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   bit model_on = 1'b0;
   int vld_cnt  = 0;
   int snd_rise = 0;
   int overlap  = 0;
   logic prev_snd = 1'b0;

   jstk_poll_if u_if ();

   jstk_poll_ctrl #(
      .CLK_HZ      (CLK_HZ),
      .POLL_HZ     (POLL_HZ),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .DEADBAND    (10'd100)
   ) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .en       (en),
      .led      (led),
      .jstk     (u_if.master),
      .x_pos    (x_pos),
      .y_pos    (y_pos),
      .btn      (btn),
      .dir      (dir),
      .data_vld (data_vld),
      .timeout  (timeout)
   );

   always #5 CLK = ~CLK;

   // PmodJSTK SS model: SS drops 4 cycles after sndRec is seen, rises 200 later.
   initial begin
      u_if.jstk_ss = 1'b1;
      forever begin
         @(negedge CLK);
         if (model_on && u_if.jstk_snd) begin
            repeat (4) @(negedge CLK);
            u_if.jstk_ss = 1'b0;
            repeat (200) @(negedge CLK);
            u_if.jstk_ss = 1'b1;
         end
      end
   end

   // Event counters
   always @(negedge CLK) begin
      if (data_vld) vld_cnt++;
      if (data_vld && timeout) overlap++;
      if (u_if.jstk_snd && !prev_snd) snd_rise++;
      prev_snd = u_if.jstk_snd;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic wait_vld(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLK);
         if (data_vld) break;
      end
      check({tag, "_vld_seen"}, 64'(data_vld), 64'd1);
   endtask

   task automatic wait_snd(input string tag, input logic lvl, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLK);
         if (u_if.jstk_snd == lvl) break;
      end
      check(tag, 64'(u_if.jstk_snd), 64'(lvl));
   endtask

   function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
      return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
   endfunction

   // Directed frames: x, y, buttons, expected dir
   logic [9:0] vx [4] = '{10'd512, 10'd0,   10'd600, 10'd700};
   logic [9:0] vy [4] = '{10'd1023, 10'd512, 10'd550, 10'd700};
   logic [3:0] vd [4] = '{4'b1000, 4'b0010, 4'b0000, 4'b1000};

   initial begin
      int cnt;
      int v0;
      int r0;

      u_if.jstk_dout = 40'h00_02_FF_03_00;
      repeat (3) @(negedge CLK);

      // Reset state
      check("rst_snd",     64'(u_if.jstk_snd), 64'd0);
      check("rst_din",     64'(u_if.jstk_din), 64'h80);
      check("rst_x",       64'(x_pos),    64'd512);
      check("rst_y",       64'(y_pos),    64'd512);
      check("rst_btn",     64'(btn),      64'd0);
      check("rst_dir",     64'(dir),      64'd0);
      check("rst_vld",     64'(data_vld), 64'd0);
      check("rst_timeout", 64'(timeout),  64'd0);
      RST = 1'b0;

      // Normal frames (first uses the literal frame value)
      model_on = 1'b1;
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) u_if.jstk_dout = mk(vx[k], vy[k], 3'b000);
         wait_vld($sformatf("f%0d", k), 1200);
         check($sformatf("f%0d_x", k),   64'(x_pos), 64'(vx[k]));
         check($sformatf("f%0d_y", k),   64'(y_pos), 64'(vy[k]));
         check($sformatf("f%0d_btn", k), 64'(btn),   64'd0);
         check($sformatf("f%0d_dir", k), 64'(dir),   64'(vd[k]));
         check($sformatf("f%0d_din", k), 64'(u_if.jstk_din), 64'h80);
         @(negedge CLK);
         check($sformatf("f%0d_vld_pulse", k), 64'(data_vld), 64'd0);
         if (k == 0) begin
            repeat (50) @(negedge CLK);
            check("f0_single_vld", 64'(vld_cnt), 64'd1);
         end
      end

      // Stuck SS: watchdog abort from REQ
      model_on = 1'b0;
      u_if.jstk_dout = mk(10'd512, 10'd0, 3'b000);
      v0 = vld_cnt;
      wait_snd("to_req", 1'b1, 1200);
      cnt = 1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (!u_if.jstk_snd) break;
         cnt++;
      end
      check("to_snd_cycles", 64'(cnt), 64'(TIMEOUT_CYC + 1));
      @(negedge CLK);
      check("to_flag", 64'(timeout),       64'd1);
      check("to_dir",  64'(dir),           64'd0);
      check("to_snd",  64'(u_if.jstk_snd), 64'd0);
      check("to_novld", 64'(vld_cnt - v0), 64'd0);
      model_on = 1'b1;
      wait_vld("to_recover", 1200);
      check("to_clear",   64'(timeout), 64'd0);
      check("to_rec_dir", 64'(dir),     64'b0100);

      // E-stop button
      led = 2'b01;
      u_if.jstk_dout = mk(10'd512, 10'd1023, 3'b001);
      wait_vld("estop", 1200);
      check("estop_dir", 64'(dir),   64'd0);
      check("estop_btn", 64'(btn),   64'd1);
      check("estop_y",   64'(y_pos), 64'd1023);
      check("estop_din", 64'(u_if.jstk_din), 64'h81);

      // Reset during XFER
      u_if.jstk_dout = mk(10'd1023, 10'd512, 3'b000);
      wait_snd("rx_req", 1'b1, 1200);
      wait_snd("rx_xfer", 1'b0, 100);
      repeat (10) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rx_snd", 64'(u_if.jstk_snd), 64'd0);
      check("rx_din", 64'(u_if.jstk_din), 64'h80);
      check("rx_x",   64'(x_pos),    64'd512);
      check("rx_y",   64'(y_pos),    64'd512);
      check("rx_btn", 64'(btn),      64'd0);
      check("rx_dir", 64'(dir),      64'd0);
      check("rx_vld", 64'(data_vld), 64'd0);
      v0 = vld_cnt;
      repeat (250) @(negedge CLK);
      check("rx_stale_novld", 64'(vld_cnt - v0), 64'd0);
      check("rx_stale_x",     64'(x_pos),        64'd512);
      wait_vld("rx_next", 1200);
      check("rx_next_dir", 64'(dir),   64'b0001);
      check("rx_next_x",   64'(x_pos), 64'd1023);

      // Enable dropped mid-frame, LED change mid-frame
      u_if.jstk_dout = mk(10'd100, 10'd512, 3'b000);
      wait_snd("en_req", 1'b1, 1200);
      wait_snd("en_xfer", 1'b0, 100);
      en  = 1'b0;
      led = 2'b11;
      wait_vld("en_frame", 400);
      check("en_dir", 64'(dir),   64'b0010);
      check("en_x",   64'(x_pos), 64'd100);
      check("en_din_hold", 64'(u_if.jstk_din), 64'h81);
      r0 = snd_rise;
      repeat (1000) @(negedge CLK);
      check("en_no_req", 64'(snd_rise - r0), 64'd0);
      en = 1'b1;
      wait_snd("en_resume", 1'b1, 1200);
      check("en_din_new", 64'(u_if.jstk_din), 64'h83);
      wait_vld("en_resume_frame", 400);
      check("en_resume_dir", 64'(dir), 64'b0010);

      check("vld_timeout_overlap", 64'(overlap), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
